// File: rtl/cache_arbiter_if.sv
// Bundle of the icache, dcache and memory-adaptor line ports
// that meet at the cache arbiter.
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
);
   logic                  icache_read;
   logic [ADDR_WIDTH-1:0] icache_address;
   logic [LINE_WIDTH-1:0] icache_rdata;
   logic                  icache_resp;

   logic                  dcache_read;
   logic                  dcache_write;
   logic [ADDR_WIDTH-1:0] dcache_address;
   logic [LINE_WIDTH-1:0] dcache_wdata;
   logic [LINE_WIDTH-1:0] dcache_rdata;
   logic                  dcache_resp;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  mem_resp;

   modport slave (
      input  icache_read, icache_address,
      input  dcache_read, dcache_write,
      input  dcache_address, dcache_wdata,
      input  mem_rdata, mem_resp,
      output icache_rdata, icache_resp,
      output dcache_rdata, dcache_resp,
      output mem_read, mem_write,
      output mem_address, mem_wdata
   );

   modport master (
      output icache_read, icache_address,
      output dcache_read, dcache_write,
      output dcache_address, dcache_wdata,
      output mem_rdata, mem_resp,
      input  icache_rdata, icache_resp,
      input  dcache_rdata, dcache_resp,
      input  mem_read, mem_write,
      input  mem_address, mem_wdata
   );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-sized memory port
// between the instruction and data caches.
module cache_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input logic           clk,
   input logic           rst,
   cache_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;

   logic [1:0]            state;
   logic                  last_grant;
   logic                  req_i;
   logic                  req_d;
   logic                  rd;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LINE_WIDTH-1:0] wdata;

   assign req_i = bus.icache_read;
   assign req_d = bus.dcache_read | bus.dcache_write;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // on a tie, serve whoever was not served last
               if (req_i && (!req_d || last_grant)) begin
                  state      <= SERVE_I;
                  last_grant <= 1'b0;
               end else if (req_d) begin
                  state      <= SERVE_D;
                  last_grant <= 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (bus.mem_resp) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd              = 1'b0;
      wr              = 1'b0;
      addr            = '0;
      wdata           = '0;
      bus.icache_resp = 1'b0;
      bus.dcache_resp = 1'b0;
      case (state)
         SERVE_I: begin
            rd              = 1'b1;
            addr            = bus.icache_address;
            bus.icache_resp = bus.mem_resp;
         end
         SERVE_D: begin
            // read+write together is illegal; write wins
            rd              = bus.dcache_read & ~bus.dcache_write;
            wr              = bus.dcache_write;
            addr            = bus.dcache_address;
            wdata           = bus.dcache_wdata;
            bus.dcache_resp = bus.mem_resp;
         end
         default: ;
      endcase
   end

   assign bus.mem_read     = rd;
   assign bus.mem_write    = wr;
   assign bus.mem_address  = addr;
   assign bus.mem_wdata    = wdata;
   assign bus.icache_rdata = bus.mem_rdata;
   assign bus.dcache_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed vector bench for cache_arbiter: cycle table
// plus hand sequences for fill, pending and reset cases.
module tb_cache_arbiter;
   logic clk;
   logic rst;
   int   passed;
   int   total;

   localparam logic [31:0]  IADDR = 32'h0000_0060;
   localparam logic [31:0]  DADDR = 32'h0000_1000;
   localparam logic [255:0] WDATA = {8{32'hDEADBEEF}};
   localparam logic [255:0] RDATA = {32{8'hA5}};

   cache_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

   cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       ir;
      logic       dr;
      logic       dw;
      logic       resp;
      logic [3:0] ctrl;
      logic [1:0] asel;
      logic       wsel;
   } vec_t;

   vec_t vec [17];

   task automatic chk(input string nm,
                      input logic [255:0] act,
                      input logic [255:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ctrl_now();
      return {bus.mem_read, bus.mem_write,
              bus.icache_resp, bus.dcache_resp};
   endfunction

   initial begin
      passed = 0;
      total  = 0;
      vec[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,4'b1000,2'd2,1'b1};
      vec[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,4'b1001,2'd2,1'b1};
      vec[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,4'b1010,2'd1,1'b0};
      vec[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,4'b1001,2'd2,1'b1};
      vec[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,2'd0,1'b0};
      vec[10] = '{1'b1,1'b1,1'b1,1'b0,1'b1,4'b1010,2'd1,1'b0};
      vec[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'b0000,2'd0,1'b0};
      vec[12] = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'b0000,2'd0,1'b0};
      vec[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0,4'b0100,2'd2,1'b1};
      vec[14] = '{1'b1,1'b0,1'b1,1'b1,1'b0,4'b0100,2'd2,1'b1};
      vec[15] = '{1'b1,1'b0,1'b0,1'b1,1'b1,4'b0101,2'd2,1'b1};
      vec[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'b0000,2'd0,1'b0};

      rst                = 1'b0;
      bus.icache_read    = 1'b1;
      bus.icache_address = IADDR;
      bus.dcache_read    = 1'b1;
      bus.dcache_write   = 1'b0;
      bus.dcache_address = DADDR;
      bus.dcache_wdata   = WDATA;
      bus.mem_rdata      = RDATA;
      bus.mem_resp       = 1'b0;
      @(posedge clk);

      for (int i = 0; i < 17; i++) begin
         logic [31:0]  ea;
         logic [255:0] ew;
         #1;
         rst              = vec[i].r;
         bus.icache_read  = vec[i].ir;
         bus.dcache_read  = vec[i].dr;
         bus.dcache_write = vec[i].dw;
         bus.mem_resp     = vec[i].resp;
         #1;
         ea = (vec[i].asel == 2'd1) ? IADDR :
              (vec[i].asel == 2'd2) ? DADDR : 32'h0;
         ew = vec[i].wsel ? WDATA : 256'h0;
         chk($sformatf("vec%0d_ctrl", i), 256'(ctrl_now()),
             256'(vec[i].ctrl));
         chk($sformatf("vec%0d_addr", i), 256'(bus.mem_address),
             256'(ea));
         chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, ew);
         @(posedge clk);
      end

      // single icache fill, adaptor answers on 4th serve cycle
      #1;
      bus.icache_read = 1'b1;
      bus.mem_resp    = 1'b0;
      tick();
      chk("ifill_grant", 256'(ctrl_now()), 256'(4'b1000));
      chk("ifill_addr", 256'(bus.mem_address), 256'(IADDR));
      for (int k = 1; k <= 4; k++) begin
         bus.mem_resp = (k == 4);
         #1;
         chk($sformatf("ifill_c%0d", k), 256'(ctrl_now()),
             (k == 4) ? 256'(4'b1010) : 256'(4'b1000));
         if (k == 4)
            chk("ifill_rdata", bus.icache_rdata, RDATA);
         tick();
      end
      bus.icache_read = 1'b0;
      bus.mem_resp    = 1'b0;
      #1;
      chk("ifill_resp_once", 256'(ctrl_now()), 256'(4'b0000));
      tick();

      // icache pending while dcache waits 10 cycles
      bus.dcache_read = 1'b1;
      tick();
      bus.icache_read = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("pend_c%0d", k), 256'(ctrl_now()),
             256'(4'b1000));
         tick();
      end
      bus.mem_resp = 1'b1;
      #1;
      chk("pend_dresp", 256'(ctrl_now()), 256'(4'b1001));
      tick();
      bus.dcache_read = 1'b0;
      bus.mem_resp    = 1'b0;
      #1;
      chk("pend_idle", 256'(ctrl_now()), 256'(4'b0000));
      tick();
      chk("pend_igrant", 256'(ctrl_now()), 256'(4'b1000));
      chk("pend_iaddr", 256'(bus.mem_address), 256'(IADDR));
      bus.mem_resp = 1'b1;
      #1;
      chk("pend_iresp", 256'(ctrl_now()), 256'(4'b1010));
      tick();
      bus.icache_read = 1'b0;
      bus.mem_resp    = 1'b0;
      tick();

      // reset while serving a dcache write-back
      bus.dcache_write = 1'b1;
      tick();
      chk("rst_mid_serve", 256'(ctrl_now()), 256'(4'b0100));
      rst = 1'b0;
      tick();
      chk("rst_mid_drop", 256'(ctrl_now()), 256'(4'b0000));
      chk("rst_mid_wdata", bus.mem_wdata, 256'h0);
      rst              = 1'b1;
      bus.dcache_write = 1'b0;
      bus.icache_read  = 1'b1;
      tick();
      chk("rst_after_grant", 256'(ctrl_now()), 256'(4'b1000));
      bus.mem_resp = 1'b1;
      #1;
      chk("rst_after_resp", 256'(ctrl_now()), 256'(4'b1010));
      tick();
      bus.icache_read = 1'b0;
      bus.mem_resp    = 1'b0;
      #1;
      chk("rst_after_idle", 256'(ctrl_now()), 256'(4'b0000));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
